data_mem: RTL and testbench

Single-port data memory that serves the CPU core's data-memory interface (`r_v`, `w_v`, `data_adr`, `data_o`, `strobe` in; `dmem_resp`, `dmem_resp_v` out). It sits directly downstream of the core's `mem` stage. It captures one load/store request, waits a programmable number of cycles, performs a byte-strobed write or a word read on an internal word array, and returns a one-cycle response pulse. It models the system data RAM for simulation and FPGA builds.

---
 rtl/data_mem_if.sv | 34 +++
 rtl/data_mem.sv | 166 ++++++++++++++++
 tb/tb_data_mem.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the core's mem stage and
// the data memory.
//
// Handshake: the master raises r_v and/or w_v together with data_adr,
// data_o and strobe, and holds them until it sees dmem_resp_v. The slave
// samples the request only while idle, so a request held through the
// response cycle is not taken twice. dmem_resp_v is a one-cycle pulse.
// dmem_resp and dmem_err are meaningful only in that cycle. There is no
// separate ready. The response pulse is the only acknowledge.
//
// Signals (master -> slave): r_v, w_v, data_adr[xlen], data_o[xlen], strobe[4]
// Signals (slave -> master): dmem_resp[xlen], dmem_resp_v, dmem_err
interface data_mem_if #(
  parameter int xlen = 32
);
  logic            r_v;
  logic            w_v;
  logic [xlen-1:0] data_adr;
  logic [xlen-1:0] data_o;
  logic [3:0]      strobe;
  logic [xlen-1:0] dmem_resp;
  logic            dmem_resp_v;
  logic            dmem_err;

  modport master (
    output r_v, w_v, data_adr, data_o, strobe,
    input  dmem_resp, dmem_resp_v, dmem_err
  );

  modport slave (
    input  r_v, w_v, data_adr, data_o, strobe,
    output dmem_resp, dmem_resp_v, dmem_err
  );
endinterface

// File: rtl/data_mem.sv
// data_mem: single-port data RAM for the core's data-memory interface.
// It captures one load/store and waits `latency` cycles. It then performs
// a byte-strobed write or a word read, and returns a one-cycle response.
//
// Parameters: xlen (data/address width), depth (words, power of two),
//             latency (1..15 cycles from capture to response state)
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   bus      slave modport of data_mem_if (request in, response out)
//   state_o  out  current FSM state (0 idle, 1 wait, 2 resp) for debug
//
// Array contents are not reset and start undefined.
module data_mem #(
  parameter int xlen    = 32,
  parameter int depth   = 1024,
  parameter int latency = 2
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus,
  output logic [1:0] state_o
);

  localparam int AW = $clog2(depth);
  localparam logic [3:0] CNT_INIT = 4'(latency - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  // Request captured in idle.
  logic [xlen-1:0] adr_q;
  logic [xlen-1:0] data_q;
  logic [3:0]      strb_q;
  logic            wr_q;

  // Registered response outputs.
  logic [xlen-1:0] resp_q, resp_d;
  logic            resp_v_q, resp_v_d;
  logic            err_q, err_d;

  logic [xlen-1:0] mem_q [depth];

  logic            req;
  logic            capture;
  logic            enter_resp;
  logic [xlen-1:0] acc_adr;
  logic [xlen-1:0] acc_data;
  logic [3:0]      acc_strb;
  logic            acc_wr;
  logic [AW-1:0]   acc_idx;
  logic            acc_oor;
  logic            unused_adr_lsb;

  assign req     = bus.r_v | bus.w_v;
  assign capture = (state_q == S_IDLE) && req;

  // Byte offset bits never select anything; the word is always used whole.
  assign unused_adr_lsb = ^{bus.data_adr[1:0], adr_q[1:0]};

  // State register, capture registers and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      wr_q     <= 1'b0;
      resp_q   <= '0;
      resp_v_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resp_q   <= resp_d;
      resp_v_q <= resp_v_d;
      err_q    <= err_d;
      if (capture) begin
        adr_q  <= bus.data_adr;
        data_q <= bus.data_o;
        strb_q <= bus.strobe;
        // A simultaneous read and write is treated as a write.
        wr_q   <= bus.w_v;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = CNT_INIT;
          state_d = (latency == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // The request is still held here. Returning to idle without
        // looking at it prevents a second capture.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic. The access happens on the edge that enters RESP. With
  // latency 1 that edge is also the capture edge. In that case the
  // operands come straight from the bus rather than the capture registers.
  always_comb begin
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    if (state_q == S_IDLE) begin
      acc_adr  = bus.data_adr;
      acc_data = bus.data_o;
      acc_strb = bus.strobe;
      acc_wr   = bus.w_v;
    end else begin
      acc_adr  = adr_q;
      acc_data = data_q;
      acc_strb = strb_q;
      acc_wr   = wr_q;
    end
    acc_idx  = acc_adr[AW+1:2];
    acc_oor  = |acc_adr[xlen-1:AW+2];
    resp_v_d = enter_resp;
    err_d    = enter_resp && acc_oor;
    // The read data is held between responses.
    resp_d   = resp_q;
    if (enter_resp) begin
      resp_d = (!acc_wr && !acc_oor) ? mem_q[acc_idx] : '0;
    end
  end

  // Word array: only enabled lanes are written, and only when in range.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_wr && !acc_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_strb[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
        end
      end
    end
  end

  assign bus.dmem_resp   = resp_q;
  assign bus.dmem_resp_v = resp_v_q;
  assign bus.dmem_err    = err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: self-checking bench for data_mem. Three instances are built,
// with latency 1, 2 and 15. Index 1 (latency 2) carries the table vectors,
// the random run and the reset case.
`timescale 1ns/1ps
module tb_data_mem;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  data_mem_if #(.xlen(32)) if_l1 ();
  data_mem_if #(.xlen(32)) if_l2 ();
  data_mem_if #(.xlen(32)) if_l15 ();

  logic        r_v_a  [3];
  logic        w_v_a  [3];
  logic [31:0] adr_a  [3];
  logic [31:0] wd_a   [3];
  logic [3:0]  strb_a [3];
  logic [31:0] resp_a [3];
  logic        resp_v_a [3];
  logic        err_a  [3];
  logic [1:0]  st_a   [3];

  assign if_l1.r_v = r_v_a[0];  assign if_l1.w_v = w_v_a[0];
  assign if_l1.data_adr = adr_a[0];  assign if_l1.data_o = wd_a[0];
  assign if_l1.strobe = strb_a[0];
  assign resp_a[0] = if_l1.dmem_resp;  assign resp_v_a[0] = if_l1.dmem_resp_v;
  assign err_a[0] = if_l1.dmem_err;

  assign if_l2.r_v = r_v_a[1];  assign if_l2.w_v = w_v_a[1];
  assign if_l2.data_adr = adr_a[1];  assign if_l2.data_o = wd_a[1];
  assign if_l2.strobe = strb_a[1];
  assign resp_a[1] = if_l2.dmem_resp;  assign resp_v_a[1] = if_l2.dmem_resp_v;
  assign err_a[1] = if_l2.dmem_err;

  assign if_l15.r_v = r_v_a[2];  assign if_l15.w_v = w_v_a[2];
  assign if_l15.data_adr = adr_a[2];  assign if_l15.data_o = wd_a[2];
  assign if_l15.strobe = strb_a[2];
  assign resp_a[2] = if_l15.dmem_resp;  assign resp_v_a[2] = if_l15.dmem_resp_v;
  assign err_a[2] = if_l15.dmem_err;

  data_mem #(.xlen(32), .depth(1024), .latency(1)) u_l1 (
    .clk(clk), .rst(rst), .bus(if_l1), .state_o(st_a[0]));
  data_mem #(.xlen(32), .depth(1024), .latency(2)) u_l2 (
    .clk(clk), .rst(rst), .bus(if_l2), .state_o(st_a[1]));
  data_mem #(.xlen(32), .depth(1024), .latency(15)) u_l15 (
    .clk(clk), .rst(rst), .bus(if_l15), .state_o(st_a[2]));

  int lat_of [3] = '{1, 2, 15};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drop(input int d);
    r_v_a[d] = 1'b0; w_v_a[d] = 1'b0;
    adr_a[d] = '0; wd_a[d] = '0; strb_a[d] = '0;
  endtask

  // Present one request and hold it until the response pulse. With
  // hold_extra set, keep holding through the edge that ends the response
  // cycle. Returns the response, the error flag, and the cycle count from
  // capture (1 = the cycle right after the capture edge).
  task automatic txn(input int d, input logic rd, input logic wr,
                     input logic [31:0] adr, input logic [31:0] wd,
                     input logic [3:0] strb, input bit hold_extra,
                     output logic [31:0] resp, output logic err, output int cyc);
    bit got;
    got = 0; cyc = 0; resp = '0; err = 1'b0;
    @(negedge clk);
    r_v_a[d] = rd; w_v_a[d] = wr; adr_a[d] = adr; wd_a[d] = wd; strb_a[d] = strb;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (resp_v_a[d]) begin
        got = 1; resp = resp_a[d]; err = err_a[d];
      end
    end
    if (!hold_extra) drop(d);
    @(negedge clk);
    chk1($sformatf("pulse_once[%0d]", d), resp_v_a[d], 1'b0);
    chk1($sformatf("err_once[%0d]", d), err_a[d], 1'b0);
    if (hold_extra) drop(d);
    chk1($sformatf("resp_seen[%0d]", d), got, 1'b1);
  endtask

  task automatic quiet(input int d, input int n);
    bit seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (resp_v_a[d]) seen = 1;
    end
    chk1($sformatf("no_recapture[%0d]", d), seen, 1'b0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [31:0] exp_resp;
    logic        exp_err;
  } vec_t;

  vec_t vt [14];

  // Reference model of the pool words used by the random run.
  logic [31:0] mdl [8];
  logic [31:0] exp_q [$];

  logic [31:0] r_resp, r_adr, r_wd, r_exp;
  logic        r_err, r_rd, r_wr, r_oor;
  logic [3:0]  r_strb;
  int          r_cyc, kind, w;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int d = 0; d < 3; d++) drop(d);
    rst = 1'b1;

    vt[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vt[10] = '{1'b1, 1'b1, 32'h0000_0013, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
    vt[12] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'hF, 32'h0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 32'h0000_0FFF, 32'h0,         4'h0, 32'h0102_0304, 1'b0};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk1("rst_resp_v", resp_v_a[1], 1'b0);
    chk1("rst_err", err_a[1], 1'b0);
    chk("rst_resp", resp_a[1], 32'h0);
    chk("rst_state", {30'b0, st_a[1]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_resp_v", resp_v_a[1], 1'b0);

    // ---- table vectors on the latency-2 instance ----
    for (int i = 0; i < 14; i++) begin
      txn(1, vt[i].rd, vt[i].wr, vt[i].adr, vt[i].wd, vt[i].strb, 1'b0,
          r_resp, r_err, r_cyc);
      chk($sformatf("vec%0d_resp", i), r_resp, vt[i].exp_resp);
      chk1($sformatf("vec%0d_err", i), r_err, vt[i].exp_err);
      chk($sformatf("vec%0d_lat", i), r_cyc, 32'd2);
    end

    // ---- latency sweep: one pulse per request, no recapture when held ----
    for (int d = 0; d < 3; d++) begin
      txn(d, 1'b0, 1'b1, 32'h40, 32'hA0B0_C000 + d, 4'hF, 1'b0, r_resp, r_err, r_cyc);
      chk($sformatf("sweep_wlat[%0d]", d), r_cyc, lat_of[d]);
      txn(d, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, r_resp, r_err, r_cyc);
      chk($sformatf("sweep_rlat[%0d]", d), r_cyc, lat_of[d]);
      chk($sformatf("sweep_rdata[%0d]", d), r_resp, 32'hA0B0_C000 + d);
      quiet(d, lat_of[d] + 3);
    end

    // ---- randomized run against the word model ----
    for (int i = 0; i < 8; i++) begin
      r_wd = $urandom;
      txn(1, 1'b0, 1'b1, 32'h100 + i * 4, r_wd, 4'hF, 1'b0, r_resp, r_err, r_cyc);
      mdl[i] = r_wd;
      chk("pool_init_resp", r_resp, 32'h0);
    end
    for (int n = 0; n < 60; n++) begin
      kind   = $urandom_range(0, 3);
      w      = $urandom_range(0, 7);
      r_adr  = 32'h100 + w * 4 + $urandom_range(0, 3);
      r_wd   = $urandom;
      r_strb = 4'($urandom_range(0, 15));
      r_rd   = 1'b0;
      r_wr   = 1'b0;
      case (kind)
        0: r_rd = 1'b1;
        1: r_wr = 1'b1;
        2: begin r_rd = 1'b1; r_wr = 1'b1; end
        default: begin
          r_adr = (32'h1000 << $urandom_range(0, 19)) | ($urandom & 32'hFFF);
          r_rd  = 1'($urandom_range(0, 1));
          r_wr  = !r_rd;
        end
      endcase
      // Memory is 1024 words = 4096 bytes; anything at or above that is an error.
      r_oor = (r_adr >= 32'd4096);
      if (r_oor) begin
        r_exp = 32'h0;
      end else if (r_wr) begin
        r_exp = 32'h0;
        for (int b = 0; b < 4; b++)
          if (r_strb[b]) mdl[w][8*b +: 8] = r_wd[8*b +: 8];
      end else begin
        r_exp = mdl[w];
      end
      exp_q.push_back(r_exp);
      txn(1, r_rd, r_wr, r_adr, r_wd, r_strb, 1'b0, r_resp, r_err, r_cyc);
      chk($sformatf("rnd%0d_resp", n), r_resp, exp_q.pop_front());
      chk1($sformatf("rnd%0d_err", n), r_err, r_oor);
      chk($sformatf("rnd%0d_lat", n), r_cyc, 32'd2);
    end

    // ---- reset during WAIT of a write ----
    txn(1, 1'b0, 1'b1, 32'h20, 32'h1111_1111, 4'hF, 1'b0, r_resp, r_err, r_cyc);
    txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, r_resp, r_err, r_cyc);
    chk("rw_pre", r_resp, 32'h1111_1111);
    @(negedge clk);
    chk("resp_holds", resp_a[1], 32'h1111_1111);
    r_v_a[1] = 1'b0; w_v_a[1] = 1'b1; adr_a[1] = 32'h20;
    wd_a[1] = 32'h2222_2222; strb_a[1] = 4'hF;
    @(posedge clk);
    #2;
    chk1("in_wait", st_a[1] != 2'd0, 1'b1);
    rst = 1'b1;
    drop(1);
    #1;
    chk("mid_rst_resp", resp_a[1], 32'h0);
    chk1("mid_rst_resp_v", resp_v_a[1], 1'b0);
    chk1("mid_rst_err", err_a[1], 1'b0);
    chk("mid_rst_state", {30'b0, st_a[1]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, r_resp, r_err, r_cyc);
    chk("rst_discard", r_resp, 32'h1111_1111);
    chk("rst_after_lat", r_cyc, 32'd2);
    txn(1, 1'b0, 1'b1, 32'h20, 32'h3333_3333, 4'hF, 1'b0, r_resp, r_err, r_cyc);
    txn(1, 1'b1, 1'b0, 32'h22, 32'h0, 4'h0, 1'b0, r_resp, r_err, r_cyc);
    chk("rst_next_ok", r_resp, 32'h3333_3333);

    // ---- report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
